// File: rtl/iram_fetch_pkg.sv
// Shared types and constants for the instruction-RAM fetch unit.
// The word width is a parameter of the top; the defaults here size the sub-module.
package iram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam int BYTES_PER_WORD_DEF = 4;

  // Lane index width, never below one bit so single-byte words still index cleanly.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LANE_W = lane_w(BYTES_PER_WORD_DEF);

endpackage

// File: rtl/iram_fetch_if.sv
// Decode handshake, host preload stream and single RAM port of the fetch unit.
// master = fetch unit side; slave = decode / host / RAM side.
interface iram_fetch_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BYTES_PER_WORD = 4
);

  logic                                 instr_valid;
  logic                                 instr_ready;
  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] instr_data;
  logic [ADDRESS_WIDTH-1:0]             instr_pc;

  logic                                 load_valid;
  logic                                 load_ready;
  logic [ADDRESS_WIDTH-1:0]             load_addr;
  logic [DATA_WIDTH-1:0]                load_data;

  logic                                 mem_wEn;
  logic [ADDRESS_WIDTH-1:0]             mem_addr;
  logic [DATA_WIDTH-1:0]                mem_wdata;
  logic [DATA_WIDTH-1:0]                mem_rdata;

  modport master (
    output instr_valid, instr_data, instr_pc,
    input  instr_ready,
    input  load_valid, load_addr, load_data,
    output load_ready,
    output mem_wEn, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  instr_valid, instr_data, instr_pc,
    output instr_ready,
    output load_valid, load_addr, load_data,
    input  load_ready,
    input  mem_wEn, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/iram_fetch_word_assembler.sv
// Lane-addressed byte capture register with synchronous clear.
// word shows the stored lanes merged with the lane being written this cycle.
module word_assembler
  import iram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = BYTES_PER_WORD_DEF,
  parameter int LW         = LANE_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [LW-1:0]               wr_lane,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic [DATA_WIDTH*LANES-1:0] word
);

  logic [DATA_WIDTH*LANES-1:0] word_r;

  // The bypass lets the owner latch a complete word on the edge that captures its last byte.
  always_comb begin
    word = word_r;
    for (int i = 0; i < LANES; i++) begin
      if (wr_en && (wr_lane == LW'(i))) begin
        word[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= '0;
    end else if (clr) begin
      word_r <= '0;
    end else if (wr_en) begin
      word_r <= word;
    end
  end

endmodule

// File: rtl/iram_fetch.sv
// Instruction fetch initiator: byte reads from a one-cycle-latency RAM assembled into
// little-endian words for decode, plus host preload writes while halted.
//
// state | meaning
// IDLE  | halted; preload stream owns the RAM port, mem_addr parks on pc
// FETCH | issuing byte reads pc+k and capturing each one a cycle later
// HOLD  | assembled word presented to decode, waiting for instr_ready
module iram_fetch
  import iram_pkg::*;
#(
  parameter int          DATA_WIDTH     = 8,
  parameter int          ADDRESS_WIDTH  = 8,
  parameter int          BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int unsigned RESET_PC       = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     jump_en,
  input  logic [ADDRESS_WIDTH-1:0] jump_addr,
  iram_fetch_if.master             bus
);

  localparam int                       LW        = lane_w(BYTES_PER_WORD);
  localparam int                       WW        = DATA_WIDTH * BYTES_PER_WORD;
  localparam logic [LW:0]              K_END     = (LW+1)'(BYTES_PER_WORD);
  localparam logic [LW-1:0]            LAST_LANE = LW'(BYTES_PER_WORD - 1);
  localparam logic [ADDRESS_WIDTH-1:0] PC_RST    = ADDRESS_WIDTH'(RESET_PC);
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP   = ADDRESS_WIDTH'(BYTES_PER_WORD);

  fetch_state_t             state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] pc, pc_nxt;
  logic [LW:0]              issue_k, issue_k_nxt;
  logic                     cap_vld, cap_vld_nxt;
  logic [LW-1:0]            cap_lane, cap_lane_nxt;
  logic                     armed;

  logic                     valid_r, valid_nxt;
  logic [WW-1:0]            data_r, data_nxt;
  logic [ADDRESS_WIDTH-1:0] ipc_r, ipc_nxt;

  logic                     asm_clr, asm_wr;
  logic [WW-1:0]            asm_word;

  logic                     issuing;
  logic                     last_cap;
  logic                     handshake;
  logic                     preload_wr;

  assign issuing   = (state == FETCH) && (issue_k < K_END);
  assign last_cap  = cap_vld && (cap_lane == LAST_LANE);
  assign handshake = valid_r && bus.instr_ready;

  word_assembler #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (BYTES_PER_WORD),
    .LW         (LW)
  ) u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (asm_clr),
    .wr_en   (asm_wr),
    .wr_lane (cap_lane),
    .wr_data (bus.mem_rdata),
    .word    (asm_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    issue_k_nxt  = issue_k;
    cap_vld_nxt  = 1'b0;
    cap_lane_nxt = cap_lane;
    valid_nxt    = valid_r;
    data_nxt     = data_r;
    ipc_nxt      = ipc_r;
    asm_clr      = 1'b0;
    asm_wr       = 1'b0;

    unique case (state)
      IDLE: begin
        if (jump_en) begin
          pc_nxt = jump_addr;
        end
        if (run) begin
          state_nxt   = FETCH;
          issue_k_nxt = '0;
          asm_clr     = 1'b1;
        end
      end
      FETCH: begin
        if (issuing) begin
          issue_k_nxt  = issue_k + 1'b1;
          cap_vld_nxt  = 1'b1;
          cap_lane_nxt = issue_k[LW-1:0];
        end
        asm_wr = cap_vld;
        if (last_cap) begin
          valid_nxt = 1'b1;
          data_nxt  = asm_word;
          ipc_nxt   = pc;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          valid_nxt   = 1'b0;
          pc_nxt      = pc + PC_STEP;
          state_nxt   = FETCH;
          issue_k_nxt = '0;
          asm_clr     = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Redirect and halt override the normal flow; a halt still honours a same-cycle jump.
    if (state != IDLE) begin
      if (jump_en) begin
        pc_nxt      = jump_addr;
        valid_nxt   = 1'b0;
        state_nxt   = FETCH;
        issue_k_nxt = '0;
        cap_vld_nxt = 1'b0;
        asm_clr     = 1'b1;
      end
      if (!run) begin
        state_nxt   = IDLE;
        valid_nxt   = 1'b0;
        cap_vld_nxt = 1'b0;
        asm_clr     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= PC_RST;
      issue_k  <= '0;
      cap_vld  <= 1'b0;
      cap_lane <= '0;
      valid_r  <= 1'b0;
      data_r   <= '0;
      ipc_r    <= '0;
    end else begin
      pc       <= pc_nxt;
      issue_k  <= issue_k_nxt;
      cap_vld  <= cap_vld_nxt;
      cap_lane <= cap_lane_nxt;
      valid_r  <= valid_nxt;
      data_r   <= data_nxt;
      ipc_r    <= ipc_nxt;
    end
  end

  // Keeps load_ready and mem_wEn low while reset is held and until the first clock after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  assign bus.load_ready = armed && (state == IDLE) && !run;
  assign preload_wr     = bus.load_ready && bus.load_valid;

  assign bus.mem_wEn   = preload_wr;
  assign bus.mem_wdata = preload_wr ? bus.load_data : '0;
  assign bus.mem_addr  = preload_wr ? bus.load_addr
                       : issuing    ? pc + ADDRESS_WIDTH'(issue_k)
                       :              pc;

  assign bus.instr_valid = valid_r;
  assign bus.instr_data  = data_r;
  assign bus.instr_pc    = ipc_r;

endmodule

// File: tb/tb_iram_fetch.sv
// Self-checking bench for iram_fetch: directed scenarios plus a randomized
// ready/jump run checked against a word-level reference of memory and pc flow.
module tb_iram_fetch;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       jump_en;
  logic [7:0] jump_addr;

  iram_fetch_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8), .BYTES_PER_WORD(4)) bus ();

  iram_fetch #(
    .DATA_WIDTH     (8),
    .ADDRESS_WIDTH  (8),
    .BYTES_PER_WORD (4),
    .RESET_PC       (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .bus       (bus)
  );

  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];
  int total = 0;
  int bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous byte RAM with registered read data.
  always @(posedge clk) begin
    if (bus.mem_wEn) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_word(input logic [7:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[8'(a + 8'(i))];
    return w;
  endfunction

  // Counts falling edges until instr_valid; any jump pulse is dropped after one cycle.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      jump_en = 1'b0;
      n++;
    end while (!bus.instr_valid && n < 40);
    if (!bus.instr_valid) n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    total++; if (bus.instr_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid got=%h exp=0", bus.instr_valid); end
    total++; if (bus.instr_data !== 32'h0)  begin bad++; $display("FAIL rst_data got=%h exp=0", bus.instr_data); end
    total++; if (bus.instr_pc !== 8'h00)    begin bad++; $display("FAIL rst_pc got=%h exp=0", bus.instr_pc); end
    total++; if (bus.load_ready !== 1'b0)   begin bad++; $display("FAIL rst_load_ready got=%h exp=0", bus.load_ready); end
    total++; if (bus.mem_wEn !== 1'b0)      begin bad++; $display("FAIL rst_wen got=%h exp=0", bus.mem_wEn); end
    total++; if (bus.mem_addr !== 8'h00)    begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 8'h00)   begin bad++; $display("FAIL rst_wdata got=%h exp=0", bus.mem_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_addr  = 8'(a);
      bus.load_data  = 8'($urandom_range(0, 255));
      ref_mem[a]     = bus.load_data;
    end
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  task automatic test_preload();
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_addr  = 8'(i);
      bus.load_data  = bytes[i];
      ref_mem[i]     = bytes[i];
      #1;
      total++; if (bus.load_ready !== 1'b1)   begin bad++; $display("FAIL pre_ready got=%h exp=1", bus.load_ready); end
      total++; if (bus.mem_wEn !== 1'b1)      begin bad++; $display("FAIL pre_wen got=%h exp=1", bus.mem_wEn); end
      total++; if (bus.mem_addr !== 8'(i))    begin bad++; $display("FAIL pre_addr got=%h exp=%h", bus.mem_addr, 8'(i)); end
      total++; if (bus.mem_wdata !== bytes[i]) begin bad++; $display("FAIL pre_wdata got=%h exp=%h", bus.mem_wdata, bytes[i]); end
    end
    @(negedge clk);
    bus.load_valid = 1'b0;
    #1;
    total++; if (bus.mem_wEn !== 1'b0) begin bad++; $display("FAIL pre_wen_end got=%h exp=0", bus.mem_wEn); end
  endtask

  task automatic test_first_fetch();
    int n;
    @(negedge clk);
    bus.instr_ready = 1'b1;
    run = 1'b1;
    wait_valid(n);
    total++; if (n !== 6)                        begin bad++; $display("FAIL first_latency got=%0d exp=6", n); end
    total++; if (bus.instr_data !== 32'h44332211) begin bad++; $display("FAIL first_data got=%h exp=44332211", bus.instr_data); end
    total++; if (bus.instr_pc !== 8'h00)          begin bad++; $display("FAIL first_pc got=%h exp=00", bus.instr_pc); end
    wait_valid(n);
    total++; if (n !== 6)                        begin bad++; $display("FAIL second_latency got=%0d exp=6", n); end
    total++; if (bus.instr_pc !== 8'h04)          begin bad++; $display("FAIL second_pc got=%h exp=04", bus.instr_pc); end
    total++; if (bus.instr_data !== exp_word(8'h04)) begin bad++; $display("FAIL second_data got=%h exp=%h", bus.instr_data, exp_word(8'h04)); end
  endtask

  task automatic test_stall();
    int n;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    wait_valid(n);
    total++; if (n !== 5)              begin bad++; $display("FAIL stall_latency got=%0d exp=5", n); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%h exp=1", bus.instr_valid); end
      total++; if (bus.instr_pc !== 8'h08)   begin bad++; $display("FAIL stall_pc got=%h exp=08", bus.instr_pc); end
      total++; if (bus.instr_data !== exp_word(8'h08)) begin bad++; $display("FAIL stall_data got=%h exp=%h", bus.instr_data, exp_word(8'h08)); end
      total++; if (bus.mem_wEn !== 1'b0)     begin bad++; $display("FAIL stall_wen got=%h exp=0", bus.mem_wEn); end
    end
    @(negedge clk);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL release_valid got=%h exp=0", bus.instr_valid); end
    wait_valid(n);
    total++; if (n !== 5)              begin bad++; $display("FAIL release_latency got=%0d exp=5", n); end
    total++; if (bus.instr_pc !== 8'h0C) begin bad++; $display("FAIL release_pc got=%h exp=0c", bus.instr_pc); end
  endtask

  task automatic test_jump_wrap();
    int n;
    @(negedge clk);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (bus.mem_addr !== 8'h12) begin bad++; $display("FAIL jw_k2_addr got=%h exp=12", bus.mem_addr); end
    jump_en   = 1'b1;
    jump_addr = 8'hFE;
    wait_valid(n);
    total++; if (n !== 6)               begin bad++; $display("FAIL jw_latency got=%0d exp=6", n); end
    total++; if (bus.instr_pc !== 8'hFE) begin bad++; $display("FAIL jw_pc got=%h exp=fe", bus.instr_pc); end
    total++; if (bus.instr_data !== exp_word(8'hFE)) begin bad++; $display("FAIL jw_data got=%h exp=%h", bus.instr_data, exp_word(8'hFE)); end
    wait_valid(n);
    total++; if (n !== 6)               begin bad++; $display("FAIL jw_next_latency got=%0d exp=6", n); end
    total++; if (bus.instr_pc !== 8'h02) begin bad++; $display("FAIL jw_next_pc got=%h exp=02", bus.instr_pc); end
    total++; if (bus.instr_data !== exp_word(8'h02)) begin bad++; $display("FAIL jw_next_data got=%h exp=%h", bus.instr_data, exp_word(8'h02)); end
  endtask

  task automatic test_jump_handshake();
    int n;
    bus.instr_ready = 1'b0;
    jump_en   = 1'b1;
    jump_addr = 8'h08;
    wait_valid(n);
    total++; if (bus.instr_pc !== 8'h08) begin bad++; $display("FAIL jh_setup_pc got=%h exp=08", bus.instr_pc); end
    bus.instr_ready = 1'b1;
    jump_en   = 1'b1;
    jump_addr = 8'h40;
    wait_valid(n);
    total++; if (n !== 6)               begin bad++; $display("FAIL jh_latency got=%0d exp=6", n); end
    total++; if (bus.instr_pc !== 8'h40) begin bad++; $display("FAIL jh_pc got=%h exp=40", bus.instr_pc); end
    total++; if (bus.instr_data !== exp_word(8'h40)) begin bad++; $display("FAIL jh_data got=%h exp=%h", bus.instr_data, exp_word(8'h40)); end
  endtask

  task automatic test_abort_refetch();
    int n;
    logic [7:0] newb;
    bus.instr_ready = 1'b0;
    jump_en   = 1'b1;
    jump_addr = 8'h10;
    @(negedge clk);
    jump_en = 1'b0;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    #1;
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL ab_valid got=%h exp=0", bus.instr_valid); end
    total++; if (bus.load_ready !== 1'b1)  begin bad++; $display("FAIL ab_load_ready got=%h exp=1", bus.load_ready); end
    total++; if (bus.mem_addr !== 8'h10)   begin bad++; $display("FAIL ab_park_addr got=%h exp=10", bus.mem_addr); end
    newb = ref_mem[8'h10] ^ 8'(($urandom_range(1, 255)));
    bus.load_valid = 1'b1;
    bus.load_addr  = 8'h10;
    bus.load_data  = newb;
    ref_mem[8'h10] = newb;
    #1;
    total++; if (bus.mem_wEn !== 1'b1) begin bad++; $display("FAIL ab_load_wen got=%h exp=1", bus.mem_wEn); end
    @(negedge clk);
    bus.load_valid  = 1'b0;
    run             = 1'b1;
    bus.instr_ready = 1'b1;
    wait_valid(n);
    total++; if (n !== 6)               begin bad++; $display("FAIL ab_latency got=%0d exp=6", n); end
    total++; if (bus.instr_pc !== 8'h10) begin bad++; $display("FAIL ab_pc got=%h exp=10", bus.instr_pc); end
    total++; if (bus.instr_data !== exp_word(8'h10)) begin bad++; $display("FAIL ab_data got=%h exp=%h", bus.instr_data, exp_word(8'h10)); end
    total++; if (bus.instr_data[7:0] !== newb) begin bad++; $display("FAIL ab_newbyte got=%h exp=%h", bus.instr_data[7:0], newb); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (bus.mem_addr !== 8'h15) begin bad++; $display("FAIL rm_fetch_addr got=%h exp=15", bus.mem_addr); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%h exp=0", bus.instr_valid); end
    total++; if (bus.instr_data !== 32'h0) begin bad++; $display("FAIL rm_data got=%h exp=0", bus.instr_data); end
    total++; if (bus.instr_pc !== 8'h00)   begin bad++; $display("FAIL rm_pc got=%h exp=0", bus.instr_pc); end
    total++; if (bus.load_ready !== 1'b0)  begin bad++; $display("FAIL rm_load_ready got=%h exp=0", bus.load_ready); end
    total++; if (bus.mem_wEn !== 1'b0)     begin bad++; $display("FAIL rm_wen got=%h exp=0", bus.mem_wEn); end
    total++; if (bus.mem_addr !== 8'h00)   begin bad++; $display("FAIL rm_addr got=%h exp=0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 8'h00)  begin bad++; $display("FAIL rm_wdata got=%h exp=0", bus.mem_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference: a word is valid 6 falling edges after a handshake or jump and stays
  // until consumed; pc advances by 4 per consumed word and a jump overrides it.
  task automatic test_random();
    int         cnt    = 6;
    logic [7:0] exp_pc = 8'h00;
    logic       rdy;
    logic       jmp;
    logic [7:0] jaddr;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (cnt > 0) cnt--;
      total++; if (bus.instr_valid !== (cnt == 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%h exp=%h", cyc, bus.instr_valid, (cnt == 0)); end
      if (cnt == 0) begin
        total++; if (bus.instr_pc !== exp_pc) begin bad++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, bus.instr_pc, exp_pc); end
        total++; if (bus.instr_data !== exp_word(exp_pc)) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, bus.instr_data, exp_word(exp_pc)); end
      end
      rdy   = ($urandom_range(0, 1) == 1);
      jmp   = ($urandom_range(0, 11) == 0);
      jaddr = 8'($urandom_range(0, 255));
      bus.instr_ready = rdy;
      jump_en   = jmp;
      jump_addr = jaddr;
      if (jmp) begin
        cnt    = 6;
        exp_pc = jaddr;
      end else if (cnt == 0 && rdy) begin
        cnt    = 6;
        exp_pc = 8'(exp_pc + 8'd4);
      end
    end
    @(negedge clk);
    jump_en = 1'b0;
  endtask

  initial begin
    run            = 1'b0;
    jump_en        = 1'b0;
    jump_addr      = 8'h00;
    bus.instr_ready = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_addr  = 8'h00;
    bus.load_data  = 8'h00;
    test_reset();
    test_fill();
    test_preload();
    test_first_fetch();
    test_stall();
    test_jump_wrap();
    test_jump_handshake();
    test_abort_refetch();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
